// File: rtl/jellyvl_periodic_pulse_gen.sv
// Multi-channel periodic trigger/pulse generator on a shared free-running time base.
// Define JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN to add the sticky per-channel overrun flag.
module jellyvl_periodic_pulse_gen #(
    parameter int NUM_CH       = 4,
    parameter int TIMER_WIDTH  = 64,
    parameter int PERIOD_WIDTH = 32,
    parameter int PULSE_WIDTH  = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               enable,
    input  logic [NUM_CH*PERIOD_WIDTH-1:0]  phase,
    input  logic [NUM_CH*PERIOD_WIDTH-1:0]  period,
    input  logic [NUM_CH*PULSE_WIDTH-1:0]   pulse_len,
    input  logic [NUM_CH*COUNT_WIDTH-1:0]   repeat_num,
    input  logic [TIMER_WIDTH-1:0]          current_time,
    output logic [NUM_CH-1:0]               trigger,
    output logic [NUM_CH-1:0]               pulse,
    output logic [NUM_CH-1:0]               done
`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0]               overrun
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    logic [PERIOD_WIDTH-1:0] time_low;
    assign time_low = current_time[PERIOD_WIDTH-1:0];

    generate
        if (TIMER_WIDTH > PERIOD_WIDTH) begin : g_unused_time
            logic unused_time_bits;
            assign unused_time_bits = ^current_time[TIMER_WIDTH-1:PERIOD_WIDTH];
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                  state;
        logic [PERIOD_WIDTH-1:0] next_time;
        logic [PERIOD_WIDTH-1:0] cfg_period;
        logic [PULSE_WIDTH-1:0]  cfg_len;
        logic [COUNT_WIDTH-1:0]  cfg_repeat;
        logic [COUNT_WIDTH-1:0]  fire_cnt;
        logic [PULSE_WIDTH-1:0]  pulse_cnt;
        logic                    trig_r;
        logic                    done_r;
        logic [PERIOD_WIDTH-1:0] diff;
        logic                    expired;
        logic                    idle_load;
        logic                    fire;
        logic                    last_fire;

        // Wrap-safe: expired while t lies within the half-range after next_time.
        assign diff      = time_low - next_time;
        assign expired   = ~diff[PERIOD_WIDTH-1];
        assign idle_load = !enable[i] || (state == ST_IDLE);
        assign fire      = !idle_load && (state == ST_WAIT) && expired;
        assign last_fire = (cfg_period == '0)
                        || ((cfg_repeat != '0) && (fire_cnt + COUNT_WIDTH'(1) == cfg_repeat));

        // NOTE: sequential state uses non-blocking assignments so every register
        // in the channel sees pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (reset) begin
                state      <= ST_IDLE;
                next_time  <= '0;
                cfg_period <= '0;
                cfg_len    <= '0;
                cfg_repeat <= '0;
                fire_cnt   <= '0;
                pulse_cnt  <= '0;
                trig_r     <= 1'b0;
                done_r     <= 1'b0;
            end else if (idle_load) begin
                state      <= enable[i] ? ST_WAIT : ST_IDLE;
                next_time  <= phase[i*PERIOD_WIDTH +: PERIOD_WIDTH];
                cfg_period <= period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
                cfg_len    <= pulse_len[i*PULSE_WIDTH +: PULSE_WIDTH];
                cfg_repeat <= repeat_num[i*COUNT_WIDTH +: COUNT_WIDTH];
                fire_cnt   <= '0;
                pulse_cnt  <= '0;
                trig_r     <= 1'b0;
                done_r     <= 1'b0;
            end else begin
                trig_r <= 1'b0;
                if (pulse_cnt != '0) begin
                    pulse_cnt <= pulse_cnt - PULSE_WIDTH'(1);
                end
                if (fire) begin
                    trig_r    <= 1'b1;
                    pulse_cnt <= cfg_len;
                    next_time <= next_time + cfg_period;
                    fire_cnt  <= fire_cnt + COUNT_WIDTH'(1);
                    if (last_fire) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                    end
                end
            end
        end

        assign trigger[i] = trig_r;
        assign pulse[i]   = (pulse_cnt != '0);
        assign done[i]    = done_r;

`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
        logic ovr_r;

        // Sticky until IDLE: a fire that cut a running pulse or followed a fire directly.
        always_ff @(posedge clk) begin
            if (reset || idle_load) begin
                ovr_r <= 1'b0;
            end else if (fire && ((pulse_cnt > PULSE_WIDTH'(1)) || trig_r)) begin
                ovr_r <= 1'b1;
            end
        end

        assign overrun[i] = ovr_r;
`endif
    end

endmodule

// File: tb/tb_jellyvl_periodic_pulse_gen.sv
// Self-checking bench for jellyvl_periodic_pulse_gen: scoreboard against a cycle model
// plus directed checks of the fire times each scenario should produce.
module tb_jellyvl_periodic_pulse_gen;

    localparam int NUM_CH = 4;
    localparam int TW     = 16;
    localparam int PW     = 8;
    localparam int LW     = 8;
    localparam int CW     = 8;
    localparam int PMASK  = (1 << PW) - 1;
    localparam int HALF   = 1 << (PW - 1);
    localparam int CMASK  = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_CH-1:0]      enable;
    logic [NUM_CH*PW-1:0]   phase;
    logic [NUM_CH*PW-1:0]   period;
    logic [NUM_CH*LW-1:0]   pulse_len;
    logic [NUM_CH*CW-1:0]   repeat_num;
    logic [TW-1:0]          current_time;
    logic [NUM_CH-1:0]      trigger;
    logic [NUM_CH-1:0]      pulse;
    logic [NUM_CH-1:0]      done;
`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
    logic [NUM_CH-1:0]      overrun;
`endif

    always #5 clk = ~clk;

    jellyvl_periodic_pulse_gen #(
        .NUM_CH      (NUM_CH),
        .TIMER_WIDTH (TW),
        .PERIOD_WIDTH(PW),
        .PULSE_WIDTH (LW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .phase       (phase),
        .period      (period),
        .pulse_len   (pulse_len),
        .repeat_num  (repeat_num),
        .current_time(current_time),
        .trigger     (trigger),
        .pulse       (pulse),
        .done        (done)
`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    typedef struct packed {
        logic [NUM_CH-1:0] trig;
        logic [NUM_CH-1:0] pls;
        logic [NUM_CH-1:0] dn;
        logic [NUM_CH-1:0] ovr;
    } sb_entry_t;

    typedef struct {
        int ch;
        int t;
        int cyc;
    } fire_rec_t;

    sb_entry_t sb[$];
    fire_rec_t fires[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [TW-1:0] t_sampled;

    // reference model state (0 idle, 1 wait, 2 done)
    int m_state[NUM_CH];
    int m_next[NUM_CH];
    int m_per[NUM_CH];
    int m_len[NUM_CH];
    int m_rep[NUM_CH];
    int m_cnt[NUM_CH];
    int m_pcnt[NUM_CH];
    bit m_trig[NUM_CH];
    bit m_done[NUM_CH];
    bit m_ovr[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int ch, input int ph, input int per, input int len, input int rep);
        phase[ch*PW +: PW]      = PW'(ph);
        period[ch*PW +: PW]     = PW'(per);
        pulse_len[ch*LW +: LW]  = LW'(len);
        repeat_num[ch*CW +: CW] = CW'(rep);
    endtask

    task automatic model_step();
        int t;
        t = int'(current_time[PW-1:0]);
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_state[c] = 0; m_next[c] = 0; m_cnt[c] = 0; m_pcnt[c] = 0;
                m_trig[c] = 0;  m_done[c] = 0; m_ovr[c] = 0;
            end else if (!enable[c] || m_state[c] == 0) begin
                m_next[c]  = int'(phase[c*PW +: PW]);
                m_per[c]   = int'(period[c*PW +: PW]);
                m_len[c]   = int'(pulse_len[c*LW +: LW]);
                m_rep[c]   = int'(repeat_num[c*CW +: CW]);
                m_cnt[c]   = 0; m_pcnt[c] = 0;
                m_trig[c]  = 0; m_done[c] = 0; m_ovr[c] = 0;
                m_state[c] = enable[c] ? 1 : 0;
            end else if (m_state[c] == 1 && ((t - m_next[c]) & PMASK) < HALF) begin
                if (m_pcnt[c] > 1 || m_trig[c]) m_ovr[c] = 1;
                m_trig[c] = 1;
                m_pcnt[c] = m_len[c];
                m_next[c] = (m_next[c] + m_per[c]) & PMASK;
                m_cnt[c]  = (m_cnt[c] + 1) & CMASK;
                if (m_per[c] == 0 || (m_rep[c] != 0 && m_cnt[c] == m_rep[c])) begin
                    m_state[c] = 2;
                    m_done[c]  = 1;
                end
            end else begin
                m_trig[c] = 0;
                if (m_pcnt[c] > 0) m_pcnt[c]--;
            end
        end
    endtask

    // One clock: model predicts, DUT advances, scoreboard compares.
    task automatic tick();
        sb_entry_t e;
        model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            e.trig[c] = m_trig[c];
            e.pls[c]  = (m_pcnt[c] != 0);
            e.dn[c]   = m_done[c];
            e.ovr[c]  = m_ovr[c];
        end
        sb.push_back(e);
        t_sampled = current_time;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("trigger", 32'(trigger), 32'(e.trig));
        check("pulse", 32'(pulse), 32'(e.pls));
        check("done", 32'(done), 32'(e.dn));
`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
        check("overrun", 32'(overrun), 32'(e.ovr));
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (trigger[c] === 1'b1) fires.push_back('{c, int'(t_sampled[PW-1:0]), cyc});
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            current_time = current_time + 1'b1;
        end
    endtask

    // Compare the logged fire times of one channel against up to four expected times.
    task automatic check_fires(input string tag, input int ch, input int n,
                               input int t0, input int t1, input int t2, input int t3);
        int tv[4];
        int k;
        tv = '{t0, t1, t2, t3};
        k  = 0;
        foreach (fires[i]) begin
            if (fires[i].ch == ch) begin
                if (k < n && k < 4) check({tag, "_time"}, 32'(fires[i].t), 32'(tv[k]));
                k++;
            end
        end
        check({tag, "_count"}, 32'(k), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        enable       = '0;
        phase        = '0;
        period       = '0;
        pulse_len    = '0;
        repeat_num   = '0;
        current_time = '0;
        tick(); tick(); tick();
        check("reset_state", 32'({trigger, pulse, done}), 32'd0);
        reset = 1'b0;

        // free-running ch0 and three-shot ch1
        set_cfg(0, 100, 50, 3, 0);
        set_cfg(1, 20, 10, 2, 3);
        enable = 4'b0011;
        fires.delete();
        run(231);
        check_fires("ch0_fires", 0, 3, 100, 150, 200, 0);
        check_fires("ch1_fires", 1, 3, 20, 30, 40, 0);
        check("ch1_done", 32'(done[1]), 32'd1);
        check("ch0_not_done", 32'(done[0]), 32'd0);
        enable[1] = 1'b0;
        tick();
        check("ch1_done_clear", 32'(done[1]), 32'd0);

        // time base wrap on ch2
        enable = '0;
        set_cfg(2, 250, 10, 1, 0);
        current_time = 16'd240;
        tick();
        enable = 4'b0100;
        fires.delete();
        run(26);
        check_fires("wrap_fires", 2, 2, 250, 4, 0, 0);

        // catch-up after a time jump on ch3
        enable = '0;
        set_cfg(3, 100, 10, 2, 0);
        current_time = '0;
        tick();
        enable = 4'b1000;
        tick();
        current_time = 16'd135;
        fires.delete();
        for (int k = 0; k < 6; k++) tick();
        check_fires("catchup_fires", 3, 4, 135, 135, 135, 135);
        foreach (fires[i]) check("catchup_consecutive", 32'(fires[i].cyc - fires[0].cyc), 32'(i));
`ifdef JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN
        check("catchup_overrun", 32'(overrun[3]), 32'd1);
`endif

        // retrigger holds pulse high; enable drop truncates it
        enable = '0;
        set_cfg(0, 5, 10, 20, 0);
        current_time = '0;
        tick();
        enable = 4'b0001;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k >= 5) check("ch0_pulse_hold", 32'(pulse[0]), 32'd1);
            current_time = current_time + 1'b1;
        end
        enable = '0;
        tick();
        check("ch0_pulse_cut", 32'(pulse[0]), 32'd0);

        // all channels active, one-shot on ch1, then reset mid-pulse and restart
        set_cfg(0, 2, 4, 8, 0);
        set_cfg(1, 3, 0, 5, 0);
        set_cfg(2, 4, 6, 3, 2);
        set_cfg(3, 1, 5, 10, 0);
        current_time = '0;
        tick();
        enable = 4'b1111;
        run(10);
        check("oneshot_done", 32'(done[1]), 32'd1);
        check("pulse_active_before_reset", 32'(pulse[0]), 32'd1);
        reset = 1'b1;
        tick();
        check("reset_mid_pulse", 32'({trigger, pulse, done}), 32'd0);
        reset = 1'b0;
        set_cfg(0, 20, 0, 2, 0);
        enable = 4'b0001;
        current_time = 16'd10;
        fires.delete();
        run(15);
        check_fires("restart_fires", 0, 1, 20, 0, 0, 0);
        check("restart_done", 32'(done[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jellyvl_periodic_pulse_gen.md
Name: jellyvl_periodic_pulse_gen

Overview:
- Multi-channel periodic trigger and pulse generator driven by a shared free-running time base.
- Each channel has its own phase, period, pulse width and repeat count. It emits a one-cycle trigger strobe and a stretched pulse.
- Comparison is wrap-safe, so it works across time-base rollover.
- Sits beside the system timer and feeds camera/ADC/sync strobes.

Parameters:
- NUM_CH, 4, number of independent channels
- TIMER_WIDTH, 64, width of current_time
- PERIOD_WIDTH, 32, width of phase/period; only current_time[PERIOD_WIDTH-1:0] is used
- PULSE_WIDTH, 16, width of the pulse-length field
- COUNT_WIDTH, 16, width of the repeat-count field

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  NUM_CH  per-channel run enable
- phase  input  NUM_CH*PERIOD_WIDTH  first trigger time (low bits, absolute); channel i at [i*PERIOD_WIDTH +: PERIOD_WIDTH]
- period  input  NUM_CH*PERIOD_WIDTH  trigger interval
- pulse_len  input  NUM_CH*PULSE_WIDTH  pulse length in cycles
- repeat_num  input  NUM_CH*COUNT_WIDTH  number of triggers; 0 = infinite
- current_time  input  TIMER_WIDTH  shared time base
- trigger  output  NUM_CH  one-cycle strobe per fire
- pulse  output  NUM_CH  stretched pulse
- done  output  NUM_CH  repeat count exhausted

Behaviour:
- Reset values: trigger, pulse, done, all counters and next_time are 0. All channels go to IDLE.
- Per-channel FSM with states IDLE, WAIT, DONE. The pulse counter is independent of the FSM.
- IDLE (enable=0): next_time <= phase; fire_cnt <= 0; trigger, pulse and done are held at 0. Config is sampled here only. Changes while running are ignored until the next IDLE.
- IDLE -> WAIT: when enable=1.
- Expiry test: t = current_time[PERIOD_WIDTH-1:0]. d = (t - next_time) mod 2^PERIOD_WIDTH. The channel is expired when the MSB of d is 0, i.e. t is 0 to 2^(PERIOD_WIDTH-1)-1 past next_time. This is correct across timer wrap.
- WAIT and expired:
  - trigger <= 1 for exactly one cycle. Latency is 1 cycle from the clk edge sampling an expired time.
  - next_time <= next_time + period (mod 2^PERIOD_WIDTH).
  - fire_cnt increments.
  - If repeat_num != 0 and fire_cnt+1 == repeat_num, go to DONE.
- A late time base produces at most one trigger per cycle. Missed periods catch up on consecutive cycles and are never dropped.
- period == 0: after the first trigger, go to DONE regardless of repeat_num (one-shot).
- Pulse:
  - On trigger, pulse_cnt <= pulse_len.
  - pulse is high while pulse_cnt != 0, and is asserted in the same cycle as trigger.
  - pulse_cnt decrements each cycle while nonzero.
  - pulse_len == 0 gives a trigger strobe only; pulse stays low.
- Retrigger while a pulse is active reloads pulse_cnt, so the pulse stays high continuously.
- DONE: done=1. No further triggers. A pulse in progress completes normally. DONE returns to IDLE when enable=0.
- Dropping enable in any state returns the channel to IDLE on the next cycle. trigger, pulse and done go to 0 immediately, and an in-flight pulse is truncated.
- Reset has priority over enable and overrides mid-pulse/mid-count.
- Channels are fully independent; there are no shared arbitration resources.

Optional Feature:
- Macro: JELLYVL_PERIODIC_PULSE_GEN_OVERRUN_EN.
- Defined:
  - Adds output port overrun [NUM_CH].
  - overrun is a sticky flag, set when a trigger fires while pulse_cnt > 1 (retrigger truncated a pulse), or when the channel fires on two consecutive cycles (catch-up).
  - overrun is cleared only in IDLE or by reset.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- ch0 phase=100, period=50, pulse_len=3, repeat_num=0; time counts +1/clk from 0 -> trigger strobes after time 100, 150, 200..., each 1 cycle. pulse is high 3 cycles starting with each strobe. done stays 0.
- ch1 repeat_num=3, period=10, phase=20 -> exactly 3 strobes (times 20, 30, 40), then done=1. No strobe at 50. enable=0 clears done the next cycle.
- Wrap: PERIOD_WIDTH=8, phase=250, period=10; time runs 240 -> 255 -> 0... -> strobes at 250 and 4 (260 mod 256). No spurious strobe at the wrap.
- Catch-up: time jumps from 0 to 135 with phase=100, period=10 -> 4 strobes on 4 consecutive cycles (100, 110, 120, 130). With the macro defined, overrun=1.
- pulse_len=20, period=10 -> pulse is continuously high after the first fire. enable dropped mid-pulse -> pulse=0 the next cycle.
- reset asserted mid-pulse with all channels active -> all outputs 0 the next cycle. Restart from IDLE with fresh phase works.
